periph_access_arbiter: RTL and testbench
========================================

// Module: periph_access_arbiter
// PURPOSE
//  Shares the single AXI-Lite peripheral master port between NREQ requesters
//  (pipeline MEM stage, debug/loader, DMA). Round-robin grants, one transaction in flight.
//  Issues single-cycle start pulses to the AXI master and routes read data and done back.
//  Bounds each access with a timeout.
// PARAMETERS
//  NREQ     2    number of requesters (2..8)
//  ADDR_W   32   peripheral address width
//  DATA_W   32   data width
//  TMO_CYC  255  cycles in BUSY before abort; 0 disables the timeout
// PORTS
//  Clk             in   1              single clock, rising edge
//  Rst_n           in   1              synchronous, active-low reset
//  Req             in   NREQ           per-requester access request, level, held until Done
//  ReqRW           in   NREQ           1=write 0=read, per requester
//  ReqAddr         in   NREQ*ADDR_W    packed, requester i at [i*ADDR_W +: ADDR_W]
//  ReqWData        in   NREQ*DATA_W    packed write data
//  Grant           out  NREQ           one-hot, registered, high IDLE->DONE for owner
//  Done            out  NREQ           one-cycle pulse to owner at completion
//  RData           out  DATA_W         captured read data, valid with Done, held after
//  Error           out  1              one-cycle pulse with Done when access timed out
//  StartAXIRead    out  1              one-cycle pulse, launch AXI read
//  StartAXIWrite   out  1              one-cycle pulse, launch AXI write
//  AXIAddr         out  ADDR_W         registered address of granted access
//  AXIWData        out  DATA_W         registered write data of granted access
//  AXIRData        in   DATA_W         read data from master, valid with ReadCompleted
//  ReadCompleted   in   1              read response accepted (pulse)
//  WriteCompleted  in   1              write response accepted (pulse)
// BEHAVIOUR
//  Reset: state=IDLE; Grant, Done, Error, Start*, RData, AXIAddr, AXIWData = 0; rr_ptr=0.
//  FSM states: IDLE, R_BUSY, W_BUSY, DONE.
//  IDLE: if any Req, pick the first asserted index at or after rr_ptr, cyclic.
//   Next edge: Grant[i]=1, latch AXIAddr/AXIWData, state=R_BUSY|W_BUSY by ReqRW[i].
//   Start* pulses for exactly that one cycle; rr_ptr=(i+1)%NREQ.
//  R_BUSY: on ReadCompleted latch AXIRData->RData, go to DONE. WriteCompleted ignored.
//  W_BUSY: on WriteCompleted go to DONE. ReadCompleted ignored.
//  Timeout: counter clears on entering BUSY and increments each BUSY cycle.
//   At TMO_CYC: go to DONE with Error=1; RData unchanged.
//  DONE (one cycle): Done[i]=1, Error as flagged.
//   Next edge: Grant=0, state=IDLE, new arbitration possible.
//  Latency: Req seen in IDLE -> Start 1 cycle later.
//   Completion -> Done 1 cycle later; Done -> next Start at best 2 cycles.
//  Completion on the same edge as the timeout: completion wins, Error=0.
//  Completion pulses outside the matching BUSY state are ignored, no state change.
//  Owner drops Req mid-access: access still runs to completion and Done still pulses.
//   AXI cannot abort.
//  Req/ReqRW/addr changes after grant have no effect; the latched values are used.
//  Rst_n low mid-access: immediate return to reset values.
//   Any late completion pulse then lands in IDLE and is ignored.
//  Timeout counter width = clog2(TMO_CYC+1).
// STRUCTURE
//  periph_pkg: FSM state localparams (IDLE/R_BUSY/W_BUSY/DONE), RW_READ/RW_WRITE constants.
//  Sub-module rr_arbiter #(N): comb Req+ptr -> one-hot grant + index.
//  FSM, latches and timeout live in the top.
// TESTING
//  1. Single read: Req=01, ReqRW=0, addr 0x4000_0010; ReadCompleted+AXIRData=0xDEADBEEF
//     3 cycles after Start.
//     -> one StartAXIRead pulse, Done[0] 1 cycle later, RData=0xDEADBEEF.
//  2. Contention: Req=11 held.
//     -> grants alternate 0,1,0,1; each Start pulse single; never two Grant bits set.
//  3. Timeout: TMO_CYC=8, no completion.
//     -> Done and Error pulse together 9 cycles after Start; next access proceeds normally.
//  4. Wrong/stray completion: WriteCompleted during R_BUSY, ReadCompleted in IDLE.
//     -> no state change, no Done.
//  5. Reset mid W_BUSY, WriteCompleted 2 cycles after Rst_n release.
//     -> all outputs 0, pulse ignored, rr_ptr=0.
//  6. Owner drops Req after grant.
//     -> transaction completes, Done pulses, requester 1 granted next.

Source files
------------

// File: rtl/periph_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// periph_access_arbiter_pkg
//   Shared definitions for the peripheral access arbiter: FSM state encoding,
//   read/write direction constants and an index-width helper.
// -----------------------------------------------------------------------------
package periph_access_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_R_BUSY = 2'd1,
        ST_W_BUSY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Values of ReqRW.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Bits needed to index n requesters. The result is never below 1, so a
    // single requester still gets a legal vector.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/periph_access_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   ptr, searching cyclically.
// Ports
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority index (must be < N)
//   gnt   out N      one-hot grant (all zero when no request)
//   idx   out IDX_W  index of the granted requester
//   valid out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import periph_access_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Cyclic scan from ptr; the first hit locks out later candidates.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int off = 0; off < N; off++) begin
            j  = (int'(ptr) + off) % N;
            jj = IDX_W'(j);
            if (req[jj] && !valid) begin
                gnt[jj] = 1'b1;
                idx     = jj;
                valid   = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/periph_access_arbiter.sv
// -----------------------------------------------------------------------------
// periph_access_arbiter
//   Shares one AXI-Lite master port between NREQ requesters. Round-robin
//   grant, one transaction in flight, single-cycle start pulses, read data
//   and completion routed back to the owner, every access bounded by a
//   timeout (TMO_CYC cycles in BUSY; 0 disables it).
// Ports
//   Clk, Rst_n                 clock, synchronous active-low reset
//   Req/ReqRW                  per-requester level request and direction
//   ReqAddr/ReqWData           packed per-requester address / write data
//   Grant                      one-hot owner, high from grant through DONE
//   Done/Error                 completion pulse to owner, timeout flag
//   RData                      read data captured on ReadCompleted, held
//   StartAXIRead/StartAXIWrite one-cycle launch pulses to the AXI master
//   AXIAddr/AXIWData           latched address / write data of the owner
//   AXIRData                   read data from the master
//   ReadCompleted/WriteCompleted completion pulses from the master
// -----------------------------------------------------------------------------
module periph_access_arbiter
    import periph_access_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ-1:0]          ReqRW,
    input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
    input  logic [NREQ*DATA_W-1:0]   ReqWData,
    output logic [NREQ-1:0]          Grant,
    output logic [NREQ-1:0]          Done,
    output logic [DATA_W-1:0]        RData,
    output logic                     Error,
    output logic                     StartAXIRead,
    output logic                     StartAXIWrite,
    output logic [ADDR_W-1:0]        AXIAddr,
    output logic [DATA_W-1:0]        AXIWData,
    input  logic [DATA_W-1:0]        AXIRData,
    input  logic                     ReadCompleted,
    input  logic                     WriteCompleted
);

    localparam int   IDX_W  = idx_width(NREQ);
    localparam int   TMO_W  = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic TMO_EN = (TMO_CYC != 0);

    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [NREQ-1:0]     grant_q,     grant_d;
    logic [NREQ-1:0]     done_q,      done_d;
    logic                error_q,     error_d;
    logic                start_rd_q,  start_rd_d;
    logic                start_wr_q,  start_wr_d;
    logic [ADDR_W-1:0]   axi_addr_q,  axi_addr_d;
    logic [DATA_W-1:0]   axi_wdata_q, axi_wdata_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_rw;
    logic                tmo_hit;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (Req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // One-hot AND-OR mux of the winning requester's address, data and direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rw    = RW_READ;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr  = sel_addr  | (ReqAddr[i*ADDR_W +: ADDR_W]  & {ADDR_W{arb_gnt[i]}});
            sel_wdata = sel_wdata | (ReqWData[i*DATA_W +: DATA_W] & {DATA_W{arb_gnt[i]}});
            sel_rw    = sel_rw    | (ReqRW[i] & arb_gnt[i]);
        end
    end

    assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_W'(TMO_CYC));

    // Next-state and output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        done_d      = '0;
        error_d     = 1'b0;
        start_rd_d  = 1'b0;
        start_wr_d  = 1'b0;
        axi_addr_d  = axi_addr_q;
        axi_wdata_d = axi_wdata_q;
        rdata_d     = rdata_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_gnt;
                    axi_addr_d  = sel_addr;
                    axi_wdata_d = sel_wdata;
                    tmo_cnt_d   = '0;
                    rr_ptr_d    = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    if (sel_rw == RW_WRITE) begin
                        state_d    = ST_W_BUSY;
                        start_wr_d = 1'b1;
                    end else begin
                        state_d    = ST_R_BUSY;
                        start_rd_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Completion is tested before the timeout so a same-edge tie
            // finishes cleanly without Error.
            ST_R_BUSY: begin
                if (ReadCompleted) begin
                    rdata_d = AXIRData;
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    error_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_W_BUSY: begin
                if (WriteCompleted) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    error_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            error_q     <= 1'b0;
            start_rd_q  <= 1'b0;
            start_wr_q  <= 1'b0;
            axi_addr_q  <= '0;
            axi_wdata_q <= '0;
            rdata_q     <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            error_q     <= error_d;
            start_rd_q  <= start_rd_d;
            start_wr_q  <= start_wr_d;
            axi_addr_q  <= axi_addr_d;
            axi_wdata_q <= axi_wdata_d;
            rdata_q     <= rdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign Grant         = grant_q;
    assign Done          = done_q;
    assign Error         = error_q;
    assign RData         = rdata_q;
    assign StartAXIRead  = start_rd_q;
    assign StartAXIWrite = start_wr_q;
    assign AXIAddr       = axi_addr_q;
    assign AXIWData      = axi_wdata_q;

endmodule

// File: tb/tb_periph_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_periph_access_arbiter
//   Directed bench for periph_access_arbiter (NREQ=2, TMO_CYC=8). Expected
//   transactions are queued in grant order when stimulus is applied; a
//   negedge monitor compares them at Start and pops them at Done.
// -----------------------------------------------------------------------------
module tb_periph_access_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic [1:0]  Req;
    logic [1:0]  ReqRW;
    logic [63:0] ReqAddr;
    logic [63:0] ReqWData;
    logic [1:0]  Grant;
    logic [1:0]  Done;
    logic [31:0] RData;
    logic        Error;
    logic        StartAXIRead;
    logic        StartAXIWrite;
    logic [31:0] AXIAddr;
    logic [31:0] AXIWData;
    logic [31:0] AXIRData;
    logic        ReadCompleted;
    logic        WriteCompleted;

    periph_access_arbiter #(
        .NREQ    (2),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TMO_CYC (8)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Req            (Req),
        .ReqRW          (ReqRW),
        .ReqAddr        (ReqAddr),
        .ReqWData       (ReqWData),
        .Grant          (Grant),
        .Done           (Done),
        .RData          (RData),
        .Error          (Error),
        .StartAXIRead   (StartAXIRead),
        .StartAXIWrite  (StartAXIWrite),
        .AXIAddr        (AXIAddr),
        .AXIWData       (AXIWData),
        .AXIRData       (AXIRData),
        .ReadCompleted  (ReadCompleted),
        .WriteCompleted (WriteCompleted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  gnt;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_model = 32'h0;
    logic        start_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Queue one expected transaction; RData model follows successful reads only.
    task automatic push(input logic [1:0] g, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic err);
        exp_t e;
        if (!wr && !err) rd_model = rd;
        e.gnt = g; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd_model; e.err = err;
        q.push_back(e);
    endtask

    task automatic wait_start();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (StartAXIRead || StartAXIWrite) seen = 1'b1;
        end
        chk("start_seen", 64'(seen), 64'(1));
    endtask

    // Pulse a completion now; Done must follow on the next cycle.
    task automatic complete(input logic wr, input logic [31:0] data, input logic [1:0] req_after);
        AXIRData = data;
        if (wr) WriteCompleted = 1'b1;
        else    ReadCompleted  = 1'b1;
        tick();
        ReadCompleted  = 1'b0;
        WriteCompleted = 1'b0;
        chk("done_latency", 64'(Done != 2'b00), 64'(1));
        Req = req_after;
    endtask

    // Scoreboard monitor sampling on the falling edge.
    always @(negedge Clk) begin
        exp_t e;
        if (Rst_n) begin
            chk("grant_onehot0", 64'($onehot0(Grant)), 64'(1));
            if (StartAXIRead || StartAXIWrite) begin
                chk("start_single", 64'(start_prev), 64'(0));
                chk("sb_nonempty_start", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q[0];
                    chk("start_grant", 64'(Grant), 64'(e.gnt));
                    chk("start_rw", 64'({StartAXIWrite, StartAXIRead}), e.wr ? 64'(2) : 64'(1));
                    chk("start_addr", 64'(AXIAddr), 64'(e.addr));
                    if (e.wr) chk("start_wdata", 64'(AXIWData), 64'(e.wdata));
                end
            end
            if (Done != 2'b00) begin
                chk("sb_nonempty_done", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("done_owner", 64'(Done), 64'(e.gnt));
                    chk("done_error", 64'(Error), 64'(e.err));
                    chk("done_rdata", 64'(RData), 64'(e.rdata));
                    chk("done_grant", 64'(Grant), 64'(e.gnt));
                end
            end else begin
                chk("error_without_done", 64'(Error), 64'(0));
            end
        end
        start_prev <= StartAXIRead | StartAXIWrite;
    end

    initial begin
        int n;
        Rst_n = 1'b0; Req = 2'b00; ReqRW = 2'b00; ReqAddr = 64'h0; ReqWData = 64'h0;
        AXIRData = 32'h0; ReadCompleted = 1'b0; WriteCompleted = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", 64'({Grant, Done, Error, StartAXIRead, StartAXIWrite}), 64'(0));
        chk("reset_rdata", 64'(RData), 64'(0));
        chk("reset_axi", {AXIAddr, AXIWData}, 64'(0));
        Rst_n = 1'b1;
        tick();

        // Single read, completion 3 cycles after Start.
        ReqAddr[31:0] = 32'h4000_0010; ReqWData[31:0] = 32'h1111_1111; ReqRW = 2'b00;
        push(2'b01, 1'b0, 32'h4000_0010, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0);
        Req = 2'b01;
        wait_start();
        repeat (3) tick();
        complete(1'b0, 32'hDEAD_BEEF, 2'b00);
        chk("read_rdata", 64'(RData), 64'(32'hDEAD_BEEF));

        // Stray ReadCompleted while idle.
        tick();
        AXIRData = 32'h0BAD_0BAD; ReadCompleted = 1'b1;
        tick();
        ReadCompleted = 1'b0;
        tick();
        chk("stray_rc_done", 64'(Done), 64'(0));
        chk("stray_rc_grant", 64'(Grant), 64'(0));
        chk("stray_rc_rdata", 64'(RData), 64'(32'hDEAD_BEEF));

        // Wrong completion (WriteCompleted) during a read.
        ReqAddr[31:0] = 32'h4000_0020;
        push(2'b01, 1'b0, 32'h4000_0020, 32'h1111_1111, 32'hCAFE_0001, 1'b0);
        Req = 2'b01;
        wait_start();
        WriteCompleted = 1'b1;
        tick();
        WriteCompleted = 1'b0;
        tick();
        chk("stray_wc_done", 64'(Done), 64'(0));
        chk("stray_wc_grant", 64'(Grant), 64'(2'b01));
        complete(1'b0, 32'hCAFE_0001, 2'b00);

        // Contention: pointer sits at 1, so grants run 1,0,1,0.
        tick();
        ReqAddr = {32'h4000_1000, 32'h4000_0030};
        ReqWData[63:32] = 32'hA5A5_0001; ReqRW = 2'b10;
        push(2'b10, 1'b1, 32'h4000_1000, 32'hA5A5_0001, 32'h0, 1'b0);
        push(2'b01, 1'b0, 32'h4000_0030, 32'h1111_1111, 32'h1234_0001, 1'b0);
        push(2'b10, 1'b1, 32'h4000_1000, 32'hA5A5_0002, 32'h0, 1'b0);
        push(2'b01, 1'b0, 32'h4000_0030, 32'h1111_1111, 32'h1234_0002, 1'b0);
        Req = 2'b11;
        wait_start();
        tick();
        complete(1'b1, 32'h0, 2'b11);
        ReqWData[63:32] = 32'hA5A5_0002;
        wait_start();
        tick();
        complete(1'b0, 32'h1234_0001, 2'b11);
        wait_start();
        tick();
        complete(1'b1, 32'h0, 2'b11);
        wait_start();
        tick();
        complete(1'b0, 32'h1234_0002, 2'b00);

        // Timeout: no completion, Done+Error 9 cycles after Start, RData held.
        tick();
        ReqAddr[31:0] = 32'h4000_0040; ReqRW = 2'b00;
        push(2'b01, 1'b0, 32'h4000_0040, 32'h1111_1111, 32'h0, 1'b1);
        Req = 2'b01;
        wait_start();
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            tick();
            if (Done != 2'b00) n = k;
        end
        chk("tmo_latency", 64'(n), 64'(9));
        chk("tmo_error", 64'(Error), 64'(1));
        chk("tmo_rdata", 64'(RData), 64'(32'h1234_0002));
        Req = 2'b00;
        tick();

        // Next access after the timeout runs normally.
        ReqAddr[63:32] = 32'h4000_1050; ReqWData[63:32] = 32'h5A5A_0003; ReqRW = 2'b10;
        push(2'b10, 1'b1, 32'h4000_1050, 32'h5A5A_0003, 32'h0, 1'b0);
        Req = 2'b10;
        wait_start();
        repeat (2) tick();
        complete(1'b1, 32'h0, 2'b00);
        tick();

        // Completion on the same edge as the timeout: completion wins.
        ReqAddr[31:0] = 32'h4000_0048;
        push(2'b01, 1'b0, 32'h4000_0048, 32'h1111_1111, 32'h7777_0008, 1'b0);
        Req = 2'b01;
        wait_start();
        repeat (8) tick();
        complete(1'b0, 32'h7777_0008, 2'b00);
        chk("tie_error", 64'(Error), 64'(0));
        tick();

        // Reset in the middle of a write from requester 0 (pointer would move to 1).
        ReqAddr[31:0] = 32'h4000_0050; ReqWData[31:0] = 32'h2222_2222; ReqRW = 2'b01;
        push(2'b01, 1'b1, 32'h4000_0050, 32'h2222_2222, 32'h0, 1'b0);
        Req = 2'b01;
        wait_start();
        tick();
        Rst_n = 1'b0; Req = 2'b00;
        q.delete();
        rd_model = 32'h0;
        tick();
        chk("rst_mid_ctrl", 64'({Grant, Done, Error, StartAXIRead, StartAXIWrite}), 64'(0));
        chk("rst_mid_data", {AXIAddr, RData}, 64'(0));
        Rst_n = 1'b1;
        repeat (2) tick();
        WriteCompleted = 1'b1;
        tick();
        WriteCompleted = 1'b0;
        tick();
        chk("late_wc_ctrl", 64'({Grant, Done, Error}), 64'(0));

        // Pointer back at 0: requester 0 first; it drops Req and changes inputs after grant.
        ReqAddr = {32'h4000_1060, 32'h4000_0060}; ReqRW = 2'b00;
        push(2'b01, 1'b0, 32'h4000_0060, 32'h2222_2222, 32'h6666_0000, 1'b0);
        push(2'b10, 1'b0, 32'h4000_1060, 32'h5A5A_0003, 32'h6666_0001, 1'b0);
        Req = 2'b11;
        wait_start();
        Req = 2'b10; ReqAddr[31:0] = 32'hFFFF_FFF0; ReqRW = 2'b01;
        tick();
        chk("latched_addr", 64'(AXIAddr), 64'(32'h4000_0060));
        chk("drop_grant", 64'(Grant), 64'(2'b01));
        complete(1'b0, 32'h6666_0000, 2'b10);
        ReqRW = 2'b00;
        wait_start();
        tick();
        complete(1'b0, 32'h6666_0001, 2'b00);

        repeat (3) tick();
        chk("sb_drained", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
